fx_writeback: RTL and testbench

FX_WRITEBACK -- requirements
Module: fx_writeback

---
 rtl/fx_pkg.sv | 41 ++++
 rtl/fx_wb_fifo.sv | 51 +++++
 rtl/fx_writeback.sv | 167 ++++++++++++++++
 tb/tb_fx_writeback.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared definitions for the FX writeback slice: unit codes, XER bit map, FIFO entry record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fx_pkg;

    // Functional unit codes carried with every result
    localparam logic [1:0] UNIT_FX = 2'd0;
    localparam logic [1:0] UNIT_LS = 2'd1;
    localparam logic [1:0] UNIT_BR = 2'd2;
    localparam logic [1:0] UNIT_CR = 2'd3;

    // Architected XER bit positions
    localparam int XER_SO   = 32;
    localparam int XER_OV   = 33;
    localparam int XER_CA   = 34;
    localparam int XER_OV32 = 44;
    localparam int XER_CA32 = 45;

    // One buffered FX result; cr_bits is {LT, GT, EQ}, the fourth CR bit is never stored
    typedef struct packed {
        logic        r1_en;
        logic [5:0]  r1_addr;
        logic [63:0] r1_val;
        logic        r2_en;
        logic [5:0]  r2_addr;
        logic [63:0] r2_val;
        logic        cr_en;
        logic [2:0]  cr_bits;
        logic        xer_en;
        logic        ov;
        logic        ca;
        logic        ov32;
        logic        ca32;
    } fx_entry_t;

    // An entry needs two register-file cycles only when both GPR writes are requested
    function automatic logic is_dual(input fx_entry_t e);
        return e.r1_en & e.r2_en;
    endfunction

endpackage

// File: rtl/fx_wb_fifo.sv
// Circular buffer of FX results with registered count, head visible combinationally.
// Latency: an entry pushed at edge k is at the head after edge k when the buffer was empty.
// Backpressure: caller must not push when full or pop when empty; full/empty come from flops.
module fx_wb_fifo import fx_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      push_vld,
    input  fx_entry_t push_dat,
    input  logic      pop_vld,
    output fx_entry_t head_dat,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fx_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    // Storage is data-only and needs no reset; validity is tracked by count
    always_ff @(posedge clock_i) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two; push+pop leaves count unchanged
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, pop_vld})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fx_writeback.sv
// Buffers FX results and serialises their GPR writes onto one register-file port, updating XER/CR0.
// Latency: first write appears on the registered outputs one cycle after acceptance; 1 or 2 cycles per entry.
// Backpressure: ready_o low when the buffer is full; a matching result offered while full is dropped and flagged.
module fx_writeback import fx_pkg::*; #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] FXUnitCode = UNIT_FX
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        fxValid_i,
    input  logic [1:0]  functionalUnitCode_i,
    input  logic        reg1WritebackEnable_i,
    input  logic        reg2WritebackEnable_i,
    input  logic [5:0]  reg1WritebackAddress_i,
    input  logic [5:0]  reg2WritebackAddress_i,
    input  logic [63:0] reg1WritebackVal_i,
    input  logic [63:0] reg2WritebackVal_i,
    input  logic        conditionRegWriteEnable_i,
    input  logic [3:0]  conditionRegisterBits_i,
    input  logic        xerWriteEnable_i,
    input  logic        ov_i,
    input  logic        ca_i,
    input  logic        ov32_i,
    input  logic        ca32_i,
    output logic        ready_o,
    output logic        rfWriteEnable_o,
    output logic [5:0]  rfWriteAddress_o,
    output logic [63:0] rfWriteVal_o,
    output logic        crWriteEnable_o,
    output logic [3:0]  cr0_o,
    output logic [63:0] xer_o,
    output logic        dropError_o
);

    typedef enum logic [1:0] {IDLE, WR1, WR2} wb_state_t;

    wb_state_t state;
    logic      need_wr2;
    fx_entry_t in_dat;
    fx_entry_t head_dat;
    logic      full, empty;
    logic      unit_hit, push_vld, pop_vld;
    logic      launch_wr1, launch_wr2;
    logic      so_q, ov_q, ca_q, ov32_q, ca32_q, so_next;
    logic      cr_spare_unused;

    assign cr_spare_unused = conditionRegisterBits_i[0];

    assign unit_hit = fxValid_i && (functionalUnitCode_i == FXUnitCode);
    assign push_vld = unit_hit && !full;
    assign ready_o  = !full;

    // Pack the incoming result into a buffer entry
    always_comb begin
        in_dat         = '0;
        in_dat.r1_en   = reg1WritebackEnable_i;
        in_dat.r1_addr = reg1WritebackAddress_i;
        in_dat.r1_val  = reg1WritebackVal_i;
        in_dat.r2_en   = reg2WritebackEnable_i;
        in_dat.r2_addr = reg2WritebackAddress_i;
        in_dat.r2_val  = reg2WritebackVal_i;
        in_dat.cr_en   = conditionRegWriteEnable_i;
        in_dat.cr_bits = conditionRegisterBits_i[3:1];
        in_dat.xer_en  = xerWriteEnable_i;
        in_dat.ov      = ov_i;
        in_dat.ca      = ca_i;
        in_dat.ov32    = ov32_i;
        in_dat.ca32    = ca32_i;
    end

    fx_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .push_vld (push_vld),
        .push_dat (in_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty)
    );

    // Choose what the next edge launches; an entry is popped on the edge that launches its last write
    always_comb begin
        launch_wr1 = 1'b0;
        launch_wr2 = 1'b0;
        pop_vld    = 1'b0;
        if (state == WR1 && need_wr2) begin
            launch_wr2 = 1'b1;
            pop_vld    = 1'b1;
        end else if (!empty) begin
            launch_wr1 = 1'b1;
            pop_vld    = !is_dual(head_dat);
        end
        so_next = so_q | (head_dat.xer_en & head_dat.ov);
    end

    // Drain FSM with registered register-file, XER and CR0 outputs
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state            <= IDLE;
            need_wr2         <= 1'b0;
            rfWriteEnable_o  <= 1'b0;
            rfWriteAddress_o <= '0;
            rfWriteVal_o     <= '0;
            crWriteEnable_o  <= 1'b0;
            cr0_o            <= '0;
            so_q             <= 1'b0;
            ov_q             <= 1'b0;
            ca_q             <= 1'b0;
            ov32_q           <= 1'b0;
            ca32_q           <= 1'b0;
        end else begin
            rfWriteEnable_o <= 1'b0;
            crWriteEnable_o <= 1'b0;
            if (launch_wr2) begin
                state            <= WR2;
                need_wr2         <= 1'b0;
                rfWriteEnable_o  <= 1'b1;
                rfWriteAddress_o <= head_dat.r2_addr;
                rfWriteVal_o     <= head_dat.r2_val;
            end else if (launch_wr1) begin
                state    <= WR1;
                need_wr2 <= is_dual(head_dat);
                if (head_dat.r1_en) begin
                    rfWriteEnable_o  <= 1'b1;
                    rfWriteAddress_o <= head_dat.r1_addr;
                    rfWriteVal_o     <= head_dat.r1_val;
                end else if (head_dat.r2_en) begin
                    rfWriteEnable_o  <= 1'b1;
                    rfWriteAddress_o <= head_dat.r2_addr;
                    rfWriteVal_o     <= head_dat.r2_val;
                end
                if (head_dat.xer_en) begin
                    so_q   <= so_next;
                    ov_q   <= head_dat.ov;
                    ca_q   <= head_dat.ca;
                    ov32_q <= head_dat.ov32;
                    ca32_q <= head_dat.ca32;
                end
                if (head_dat.cr_en) begin
                    crWriteEnable_o <= 1'b1;
                    cr0_o           <= {head_dat.cr_bits, so_next};
                end
            end else begin
                state    <= IDLE;
                need_wr2 <= 1'b0;
            end
        end
    end

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i)              dropError_o <= 1'b0;
        else if (unit_hit && full) dropError_o <= 1'b1;
    end

    // Place the XER status flops at their architected bit positions
    always_comb begin
        xer_o           = '0;
        xer_o[XER_SO]   = so_q;
        xer_o[XER_OV]   = ov_q;
        xer_o[XER_CA]   = ca_q;
        xer_o[XER_OV32] = ov32_q;
        xer_o[XER_CA32] = ca32_q;
    end

endmodule

// File: tb/tb_fx_writeback.sv
// Directed bench for fx_writeback: reset, single/dual writes, unit filtering, XER/CR0, streaming, overflow, mid-drain reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_fx_writeback;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        fxValid_i = 1'b0;
    logic [1:0]  functionalUnitCode_i = 2'd0;
    logic        reg1WritebackEnable_i = 1'b0, reg2WritebackEnable_i = 1'b0;
    logic [5:0]  reg1WritebackAddress_i = '0, reg2WritebackAddress_i = '0;
    logic [63:0] reg1WritebackVal_i = '0, reg2WritebackVal_i = '0;
    logic        conditionRegWriteEnable_i = 1'b0;
    logic [3:0]  conditionRegisterBits_i = '0;
    logic        xerWriteEnable_i = 1'b0, ov_i = 1'b0, ca_i = 1'b0, ov32_i = 1'b0, ca32_i = 1'b0;
    logic        ready_o, rfWriteEnable_o, crWriteEnable_o, dropError_o;
    logic [5:0]  rfWriteAddress_o;
    logic [63:0] rfWriteVal_o, xer_o;
    logic [3:0]  cr0_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [5:0]  wq_addr[$];
    logic [63:0] wq_val[$];
    int          wq_cyc[$];

    fx_writeback dut (
        .clock_i(clock_i), .reset_i(reset_i), .fxValid_i(fxValid_i),
        .functionalUnitCode_i(functionalUnitCode_i),
        .reg1WritebackEnable_i(reg1WritebackEnable_i), .reg2WritebackEnable_i(reg2WritebackEnable_i),
        .reg1WritebackAddress_i(reg1WritebackAddress_i), .reg2WritebackAddress_i(reg2WritebackAddress_i),
        .reg1WritebackVal_i(reg1WritebackVal_i), .reg2WritebackVal_i(reg2WritebackVal_i),
        .conditionRegWriteEnable_i(conditionRegWriteEnable_i), .conditionRegisterBits_i(conditionRegisterBits_i),
        .xerWriteEnable_i(xerWriteEnable_i), .ov_i(ov_i), .ca_i(ca_i), .ov32_i(ov32_i), .ca32_i(ca32_i),
        .ready_o(ready_o), .rfWriteEnable_o(rfWriteEnable_o), .rfWriteAddress_o(rfWriteAddress_o),
        .rfWriteVal_o(rfWriteVal_o), .crWriteEnable_o(crWriteEnable_o), .cr0_o(cr0_o),
        .xer_o(xer_o), .dropError_o(dropError_o)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cyc++;

    // Record every register-file write, sampled mid-cycle
    always @(negedge clock_i) begin
        if (rfWriteEnable_o === 1'b1) begin
            wq_addr.push_back(rfWriteAddress_o);
            wq_val.push_back(rfWriteVal_o);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic clr_q();
        wq_addr.delete();
        wq_val.delete();
        wq_cyc.delete();
    endtask

    task automatic clr_in();
        fxValid_i = 1'b0;
        functionalUnitCode_i = 2'd0;
        reg1WritebackEnable_i = 1'b0; reg2WritebackEnable_i = 1'b0;
        reg1WritebackAddress_i = '0;  reg2WritebackAddress_i = '0;
        reg1WritebackVal_i = '0;      reg2WritebackVal_i = '0;
        conditionRegWriteEnable_i = 1'b0; conditionRegisterBits_i = '0;
        xerWriteEnable_i = 1'b0; ov_i = 1'b0; ca_i = 1'b0; ov32_i = 1'b0; ca32_i = 1'b0;
    endtask

    task automatic set_res(input logic r1e, input logic [5:0] a1, input logic [63:0] v1,
                           input logic r2e, input logic [5:0] a2, input logic [63:0] v2,
                           input logic cre, input logic [3:0] crb,
                           input logic xe, input logic ov, input logic ca,
                           input logic ov32, input logic ca32);
        fxValid_i = 1'b1;
        functionalUnitCode_i = 2'd0;
        reg1WritebackEnable_i = r1e; reg1WritebackAddress_i = a1; reg1WritebackVal_i = v1;
        reg2WritebackEnable_i = r2e; reg2WritebackAddress_i = a2; reg2WritebackVal_i = v2;
        conditionRegWriteEnable_i = cre; conditionRegisterBits_i = crb;
        xerWriteEnable_i = xe; ov_i = ov; ca_i = ca; ov32_i = ov32; ca32_i = ca32;
    endtask

    task automatic test_reset();
        clr_in();
        reset_i = 1'b0;
        tick();
        n_checks++; if (rfWriteEnable_o !== 1'b0) begin n_fail++; $display("FAIL reset_rfwe got %b want 0", rfWriteEnable_o); end
        n_checks++; if (rfWriteAddress_o !== 6'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", rfWriteAddress_o); end
        n_checks++; if (rfWriteVal_o !== 64'd0) begin n_fail++; $display("FAIL reset_val got %h want 0", rfWriteVal_o); end
        n_checks++; if (crWriteEnable_o !== 1'b0 || cr0_o !== 4'd0) begin n_fail++; $display("FAIL reset_cr got we=%b cr0=%b want 0/0000", crWriteEnable_o, cr0_o); end
        n_checks++; if (xer_o !== 64'd0) begin n_fail++; $display("FAIL reset_xer got %h want 0", xer_o); end
        n_checks++; if (dropError_o !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b want 0", dropError_o); end
        @(negedge clock_i);
        reset_i = 1'b1;
        tick();
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
    endtask

    task automatic test_single();
        clr_q();
        set_res(1'b1, 6'd3, 64'h5, 1'b0, 6'd0, 64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clr_in();
        n_checks++; if (rfWriteEnable_o !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", rfWriteEnable_o); end
        tick();
        n_checks++; if (rfWriteEnable_o !== 1'b1 || rfWriteAddress_o !== 6'd3 || rfWriteVal_o !== 64'h5)
            begin n_fail++; $display("FAIL single_write got we=%b a=%0d v=%h want 1/3/5", rfWriteEnable_o, rfWriteAddress_o, rfWriteVal_o); end
        tick();
        n_checks++; if (rfWriteEnable_o !== 1'b0 || rfWriteAddress_o !== 6'd3 || rfWriteVal_o !== 64'h5)
            begin n_fail++; $display("FAIL single_hold got we=%b a=%0d v=%h want 0/3/5", rfWriteEnable_o, rfWriteAddress_o, rfWriteVal_o); end
        n_checks++; if (wq_addr.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", wq_addr.size()); end
    endtask

    task automatic test_dual();
        set_res(1'b1, 6'd4, 64'hAA, 1'b1, 6'd5, 64'hBB, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clr_in();
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL dual_ready0 got %b want 1", ready_o); end
        tick();
        n_checks++; if (rfWriteEnable_o !== 1'b1 || rfWriteAddress_o !== 6'd4 || rfWriteVal_o !== 64'hAA)
            begin n_fail++; $display("FAIL dual_wr1 got we=%b a=%0d v=%h want 1/4/aa", rfWriteEnable_o, rfWriteAddress_o, rfWriteVal_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL dual_ready1 got %b want 1", ready_o); end
        tick();
        n_checks++; if (rfWriteEnable_o !== 1'b1 || rfWriteAddress_o !== 6'd5 || rfWriteVal_o !== 64'hBB)
            begin n_fail++; $display("FAIL dual_wr2 got we=%b a=%0d v=%h want 1/5/bb", rfWriteEnable_o, rfWriteAddress_o, rfWriteVal_o); end
        tick();
        n_checks++; if (rfWriteEnable_o !== 1'b0) begin n_fail++; $display("FAIL dual_end got %b want 0", rfWriteEnable_o); end
    endtask

    task automatic test_wrong_unit();
        int seen = 0;
        clr_q();
        set_res(1'b1, 6'd7, 64'h77, 1'b0, 6'd0, 64'h0, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        functionalUnitCode_i = 2'd2;
        tick();
        clr_in();
        for (int i = 0; i < 4; i++) begin
            if (rfWriteEnable_o !== 1'b0 || crWriteEnable_o !== 1'b0) seen++;
            tick();
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL wrong_unit_writes got %0d want 0", seen); end
        n_checks++; if (xer_o !== 64'd0) begin n_fail++; $display("FAIL wrong_unit_xer got %h want 0", xer_o); end
        n_checks++; if (ready_o !== 1'b1 || dropError_o !== 1'b0) begin n_fail++; $display("FAIL wrong_unit_state got rdy=%b drop=%b want 1/0", ready_o, dropError_o); end
    endtask

    task automatic test_xer_cr();
        set_res(1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_res(1'b0, 6'd0, 64'h0, 1'b0, 6'd0, 64'h0, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        clr_in();
        n_checks++; if (xer_o !== 64'h0000_0007_0000_0000) begin n_fail++; $display("FAIL xer_first got %h want 0000000700000000", xer_o); end
        n_checks++; if (rfWriteEnable_o !== 1'b0) begin n_fail++; $display("FAIL xer_no_gpr got %b want 0", rfWriteEnable_o); end
        tick();
        n_checks++; if (xer_o !== 64'h0000_1001_0000_0000) begin n_fail++; $display("FAIL xer_sticky_so got %h want 0000100100000000", xer_o); end
        n_checks++; if (crWriteEnable_o !== 1'b1 || cr0_o !== 4'b1001) begin n_fail++; $display("FAIL cr0_update got we=%b cr0=%b want 1/1001", crWriteEnable_o, cr0_o); end
        tick();
        n_checks++; if (crWriteEnable_o !== 1'b0 || cr0_o !== 4'b1001) begin n_fail++; $display("FAIL cr0_pulse got we=%b cr0=%b want 0/1001", crWriteEnable_o, cr0_o); end
    endtask

    task automatic test_back_to_back();
        int rdy_low = 0;
        clr_q();
        for (int i = 0; i < 5; i++) begin
            set_res(1'b1, 6'(10 + i), 64'(256 + i), 1'b0, 6'd0, 64'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (ready_o !== 1'b1) rdy_low++;
            tick();
        end
        clr_in();
        repeat (6) tick();
        n_checks++; if (rdy_low != 0 || dropError_o !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got rdy_low=%0d drop=%b want 0/0", rdy_low, dropError_o); end
        n_checks++; if (wq_addr.size() != 5) begin n_fail++; $display("FAIL b2b_count got %0d want 5", wq_addr.size()); end
        for (int i = 0; i < wq_addr.size() && i < 5; i++) begin
            n_checks++;
            if (wq_addr[i] !== 6'(10 + i) || wq_val[i] !== 64'(256 + i) || wq_cyc[i] != wq_cyc[0] + i)
                begin n_fail++; $display("FAIL b2b_entry%0d got a=%0d v=%h dc=%0d want a=%0d v=%h dc=%0d", i, wq_addr[i], wq_val[i], wq_cyc[i] - wq_cyc[0], 10 + i, 256 + i, i); end
        end
    endtask

    task automatic test_overflow();
        clr_q();
        for (int i = 0; i < 7; i++) begin
            set_res(1'b1, 6'(20 + 2 * i), 64'(4096 + 2 * i), 1'b1, 6'(21 + 2 * i), 64'(4097 + 2 * i),
                    1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            if (i == 4) begin
                n_checks++; if (dropError_o !== 1'b0) begin n_fail++; $display("FAIL ovf_fifth_accepted got drop=%b want 0", dropError_o); end
            end
            if (i == 5) begin
                n_checks++; if (ready_o !== 1'b0 || dropError_o !== 1'b0) begin n_fail++; $display("FAIL ovf_full got rdy=%b drop=%b want 0/0", ready_o, dropError_o); end
            end
            if (i == 6) begin
                n_checks++; if (dropError_o !== 1'b1) begin n_fail++; $display("FAIL ovf_drop got %b want 1", dropError_o); end
            end
        end
        clr_in();
        repeat (16) tick();
        n_checks++; if (wq_addr.size() != 12) begin n_fail++; $display("FAIL ovf_count got %0d want 12", wq_addr.size()); end
        for (int j = 0; j < wq_addr.size() && j < 12; j++) begin
            n_checks++;
            if (wq_addr[j] !== 6'(20 + j) || wq_val[j] !== 64'(4096 + j))
                begin n_fail++; $display("FAIL ovf_write%0d got a=%0d v=%h want a=%0d v=%h", j, wq_addr[j], wq_val[j], 20 + j, 4096 + j); end
        end
        n_checks++; if (dropError_o !== 1'b1 || ready_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got drop=%b rdy=%b want 1/1", dropError_o, ready_o); end
    endtask

    task automatic test_reset_mid_drain();
        set_res(1'b1, 6'd8, 64'h11, 1'b1, 6'd9, 64'h22, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        clr_in();
        tick();
        n_checks++; if (rfWriteEnable_o !== 1'b1 || rfWriteAddress_o !== 6'd8) begin n_fail++; $display("FAIL mid_wr1 got we=%b a=%0d want 1/8", rfWriteEnable_o, rfWriteAddress_o); end
        clr_q();
        reset_i = 1'b0;
        #1;
        n_checks++; if (rfWriteEnable_o !== 1'b0 || rfWriteAddress_o !== 6'd0 || rfWriteVal_o !== 64'd0)
            begin n_fail++; $display("FAIL mid_rf_reset got we=%b a=%0d v=%h want 0/0/0", rfWriteEnable_o, rfWriteAddress_o, rfWriteVal_o); end
        n_checks++; if (xer_o !== 64'd0 || cr0_o !== 4'd0 || crWriteEnable_o !== 1'b0 || dropError_o !== 1'b0)
            begin n_fail++; $display("FAIL mid_misc_reset got xer=%h cr0=%b crwe=%b drop=%b want 0/0000/0/0", xer_o, cr0_o, crWriteEnable_o, dropError_o); end
        tick();
        @(negedge clock_i);
        reset_i = 1'b1;
        tick();
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", ready_o); end
        repeat (4) tick();
        n_checks++; if (wq_addr.size() != 0) begin n_fail++; $display("FAIL mid_no_wr2 got %0d writes want 0", wq_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_wrong_unit();
        test_xer_cr();
        test_back_to_back();
        test_overflow();
        test_reset();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
